// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int DIST_W = 5;

    localparam logic [1:0] SF_SLL = 2'b00;
    localparam logic [1:0] SF_SRL = 2'b01;
    localparam logic [1:0] SF_RSV = 2'b10;
    localparam logic [1:0] SF_SRA = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Latency: grant is combinational from req; pointer updates at the clock edge.
// Backpressure: at most one grant per cycle; the loser keeps its request.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr_q == 0 favours port 0 on a tie, 1 favours port 1.
    logic ptr_q;
    logic ptr_d;

    // Grant a lone requester outright; on a tie the pointer decides.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr_q)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // After a grant, priority passes to the other port; idle cycles hold it.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register; reset gives port 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_unit.sv
// Combinational 32-bit barrel shifter: SLL, SRL, SRA (2'b10 behaves as SRL).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
module ShiftUnit (
    input  logic [31:0] a,
    input  logic [4:0]  sdist,
    input  logic [1:0]  sf,
    output logic [31:0] sres
);

    // Select the shift flavour; any right-shift code other than SRA is logical.
    always_comb begin
        case (sf)
            2'b00:   sres = a << sdist;
            2'b11:   sres = 32'($signed(a) >>> sdist);
            default: sres = a >> sdist;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one ShiftUnit between two requesters, each with a one-entry response slot.
// Latency: result registered 1 cycle after accept; 1 op/cycle aggregate.
// Backpressure: a port is eligible only if its slot is empty or being drained this cycle.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_W      = shift_pkg::DATA_W,
    parameter int DIST_W      = shift_pkg::DIST_W,
    parameter bit ERR_ON_SF10 = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DIST_W-1:0]   req_sdist,
    input  logic [3:0]            req_sf,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic [1:0]            rsp_err
);

    slot_state_t             slot_q [2];
    slot_state_t             slot_d [2];
    logic [DATA_W-1:0]       data_q [2];
    logic [DATA_W-1:0]       data_d [2];
    logic [1:0]              err_q;
    logic [1:0]              err_d;

    logic [1:0]              elig;
    logic [1:0]              gnt;
    logic [DATA_W-1:0]       sh_a;
    logic [DIST_W-1:0]       sh_sdist;
    logic [1:0]              sh_sf;
    logic [DATA_W-1:0]       sh_res;
    logic                    sh_is_err;

    // A port may issue when its slot is free now or is being consumed this cycle;
    // masking with rst_n keeps req_ready low throughout reset.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = rst_n && req_valid[i] &&
                      ((slot_q[i] == SLOT_EMPTY) || rsp_ready[i]);
        end
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (elig),
        .gnt   (gnt)
    );

    assign req_ready = gnt;

    // Steer the shared shifter from the granted port; port 0 when idle.
    always_comb begin
        if (gnt[1]) begin
            sh_a     = req_a[DATA_W +: DATA_W];
            sh_sdist = req_sdist[DIST_W +: DIST_W];
            sh_sf    = req_sf[3:2];
        end else begin
            sh_a     = req_a[0 +: DATA_W];
            sh_sdist = req_sdist[0 +: DIST_W];
            sh_sf    = req_sf[1:0];
        end
    end

    ShiftUnit u_shift (
        .a     (sh_a),
        .sdist (sh_sdist),
        .sf    (sh_sf),
        .sres  (sh_res)
    );

    assign sh_is_err = ERR_ON_SF10 && (sh_sf == SF_RSV);

    // Slot next state: a grant loads the new result (replacing a consumed one
    // without a bubble); a consume with no grant empties the slot.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_d[i] = slot_q[i];
            data_d[i] = data_q[i];
            err_d[i]  = err_q[i];
            if (gnt[i]) begin
                slot_d[i] = SLOT_FULL;
                data_d[i] = sh_is_err ? '0 : sh_res;
                err_d[i]  = sh_is_err;
            end else if ((slot_q[i] == SLOT_FULL) && rsp_ready[i]) begin
                slot_d[i] = SLOT_EMPTY;
            end
        end
    end

    // Slot registers; reset discards any in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= SLOT_EMPTY;
                data_q[i] <= '0;
            end
            err_q <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= slot_d[i];
                data_q[i] <= data_d[i];
            end
            err_q <= err_d;
        end
    end

    // Response outputs come straight from the slot registers.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = (slot_q[i] == SLOT_FULL);
        end
    end

    assign rsp_data = {data_q[1], data_q[0]};
    assign rsp_err  = err_q;

endmodule
